// File: rtl/game_pkg.sv
`timescale 1ns/1ps
// game_pkg
// Shared types and constants for the frog game sequencer.
//   state_t          : sequencer state, encoding is also the o_state output
//   LIVES_W/LEVEL_W  : widths of the lives and level counters
//   TIMER_W          : width of the frame down-counters
//   DEF_*            : default goal line and freeze / grace lengths
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PLAY     = 2'd1,
      ST_DYING    = 2'd2,
      ST_GAMEOVER = 2'd3
   } state_t;

   localparam int LIVES_W = 2;
   localparam int LEVEL_W = 3;
   localparam int TIMER_W = 16;

   localparam int DEF_GOAL_Y       = 40;
   localparam int DEF_DEATH_FRAMES = 60;
   localparam int DEF_GRACE_FRAMES = 90;

endpackage

// File: rtl/frame_timer.sv
`timescale 1ns/1ps
// frame_timer
// Loadable down-counter stepped once per frame strobe; stops at zero.
// Ports:
//   clk      : clock
//   srst     : synchronous active-high reset, clears the count
//   load     : load load_val (takes priority over dec)
//   load_val : value to load
//   dec      : frame strobe, decrements a non-zero count
//   count    : current count
//   zero     : count == 0
module frame_timer
   import game_pkg::*;
(
   input  logic               clk,
   input  logic               srst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               dec,
   output logic [TIMER_W-1:0] count,
   output logic               zero
);

   logic [TIMER_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - TIMER_W'(1);
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);

endmodule

// File: rtl/game_ctrl.sv
`timescale 1ns/1ps
// game_ctrl
// Frame-level sequencer for the VGA frog game: folds per-pixel frog/obstacle
// overlap into a per-frame hit, runs IDLE/PLAY/DYING/GAMEOVER, keeps lives,
// score and level, gates obstacle animation and requests frog respawns.
// Optional feature macro: GAME_CTRL_GRACE_EN (post-respawn invulnerability).
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_animate      : one-cycle end-of-frame strobe
//   i_collide      : frog pixel AND obstacle pixel
//   i_frog_y1      : frog top edge
//   i_start        : debounced start button
//   o_anim_en      : obstacle animation enable
//   o_frog_rst     : frog return-to-start request
//   o_dead, o_flash: death indication and colour-mux blink
//   o_lives, o_score, o_level, o_state : game status
module game_ctrl
   import game_pkg::*;
#(
   parameter int LIVES        = 3,
   parameter int GOAL_Y       = DEF_GOAL_Y,
   parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
   parameter int GRACE_FRAMES = DEF_GRACE_FRAMES,
   parameter int MAX_LEVEL    = 7,
   parameter int SCORE_W      = 8
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_animate,
   input  logic               i_collide,
   input  logic [11:0]        i_frog_y1,
   input  logic               i_start,
   output logic               o_anim_en,
   output logic               o_frog_rst,
   output logic               o_dead,
   output logic               o_flash,
   output logic [1:0]         o_lives,
   output logic [SCORE_W-1:0] o_score,
   output logic [2:0]         o_level,
   output logic [1:0]         o_state
);

   localparam logic [TIMER_W-1:0] DEATH_T    = TIMER_W'(DEATH_FRAMES);
   localparam logic [TIMER_W-1:0] GRACE_T    = TIMER_W'(GRACE_FRAMES);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [11:0]        GOAL_LINE  = 12'(GOAL_Y);

   state_t             state_reg;
   logic [LIVES_W-1:0] lives_reg;
   logic [SCORE_W-1:0] score_reg;
   logic [LEVEL_W-1:0] level_reg;
   logic               anim_en_reg, frog_rst_reg, dead_reg, flash_reg;
   logic               hit_q, start_q;

   logic               press, frame_hit, eff_hit, goal;
   logic               start_play, respawn, play_entry;
   logic               death_load, death_dec, death_last, death_zero;
   logic [TIMER_W-1:0] death_count, death_step;
   logic               grace_active, grace_flash_entry, grace_flash_next;

   // Per-frame collision accumulator; the strobe cycle's own collision still
   // belongs to the ending frame, and the next frame starts clean.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hit_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         start_q <= i_start;
         if (i_animate)
            hit_q <= 1'b0;
         else if (i_collide)
            hit_q <= 1'b1;
      end
   end

   assign press      = i_start & ~start_q;
   assign frame_hit  = hit_q | i_collide;
   assign eff_hit    = frame_hit & ~grace_active;
   assign goal       = (i_frog_y1 < GOAL_LINE);

   assign start_play = ((state_reg == ST_IDLE) || (state_reg == ST_GAMEOVER)) && press;
   // The freeze ends on the strobe that takes the timer from 1 to 0.
   assign death_last = (death_count <= TIMER_W'(1));
   assign respawn    = (state_reg == ST_DYING) && i_animate && death_last && (lives_reg != '0);
   assign play_entry = start_play | respawn;
   assign death_load = (state_reg == ST_PLAY) && i_animate && eff_hit;
   assign death_dec  = (state_reg == ST_DYING) && i_animate;
   assign death_step = death_count - TIMER_W'(1);

   frame_timer u_death_timer (
      .clk      (i_clk),
      .srst     (i_rst),
      .load     (death_load),
      .load_val (DEATH_T),
      .dec      (death_dec),
      .count    (death_count),
      .zero     (death_zero)
   );

`ifdef GAME_CTRL_GRACE_EN
   logic [TIMER_W-1:0] grace_count, grace_step;
   logic               grace_zero;

   frame_timer u_grace_timer (
      .clk      (i_clk),
      .srst     (i_rst),
      .load     (play_entry),
      .load_val (GRACE_T),
      .dec      (i_animate),
      .count    (grace_count),
      .zero     (grace_zero)
   );

   assign grace_step        = grace_count - TIMER_W'(1);
   assign grace_active      = ~grace_zero;
   assign grace_flash_entry = GRACE_T[2];
   assign grace_flash_next  = grace_zero ? 1'b0 : grace_step[2];
`else
   assign grace_active      = 1'b0;
   assign grace_flash_entry = 1'b0;
   assign grace_flash_next  = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg    <= ST_IDLE;
         lives_reg    <= '0;
         score_reg    <= '0;
         level_reg    <= '0;
         anim_en_reg  <= 1'b1;
         frog_rst_reg <= 1'b1;
         dead_reg     <= 1'b0;
         flash_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_GAMEOVER: begin
               if (start_play) begin
                  state_reg    <= ST_PLAY;
                  lives_reg    <= LIVES_INIT;
                  score_reg    <= '0;
                  level_reg    <= '0;
                  anim_en_reg  <= 1'b1;
                  frog_rst_reg <= 1'b0;
                  dead_reg     <= 1'b0;
                  flash_reg    <= grace_flash_entry;
               end
            end
            ST_PLAY: begin
               frog_rst_reg <= 1'b0;
               if (i_animate) begin
                  if (eff_hit) begin
                     state_reg   <= ST_DYING;
                     lives_reg   <= lives_reg - LIVES_W'(1);
                     anim_en_reg <= 1'b0;
                     dead_reg    <= 1'b1;
                     flash_reg   <= DEATH_T[3];
                  end else begin
                     flash_reg <= grace_flash_next;
                     if (goal) begin
                        if (score_reg != '1)
                           score_reg <= score_reg + SCORE_W'(1);
                        if (level_reg < LEVEL_MAX)
                           level_reg <= level_reg + LEVEL_W'(1);
                        frog_rst_reg <= 1'b1;
                     end
                  end
               end
            end
            ST_DYING: begin
               if (i_animate) begin
                  if (death_last) begin
                     frog_rst_reg <= 1'b1;
                     if (lives_reg == '0) begin
                        state_reg <= ST_GAMEOVER;
                        flash_reg <= 1'b0;
                     end else begin
                        state_reg   <= ST_PLAY;
                        anim_en_reg <= 1'b1;
                        dead_reg    <= 1'b0;
                        flash_reg   <= grace_flash_entry;
                     end
                  end else begin
                     flash_reg <= death_step[3];
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign o_state    = state_reg;
   assign o_lives    = lives_reg;
   assign o_score    = score_reg;
   assign o_level    = level_reg;
   assign o_anim_en  = anim_en_reg;
   assign o_frog_rst = frog_rst_reg;
   assign o_dead     = dead_reg;
   assign o_flash    = flash_reg;

endmodule

// File: tb/tb_game_ctrl.sv
`timescale 1ns/1ps
// tb_game_ctrl
// Directed scenarios for game_ctrl with default parameters. Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point.
module tb_game_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        animate = 1'b0;
   logic        collide = 1'b0;
   logic [11:0] frog_y1 = 12'd400;
   logic        start = 1'b0;
   logic        anim_en, frog_rst, dead, flash;
   logic [1:0]  lives, st;
   logic [7:0]  score;
   logic [2:0]  level;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   game_ctrl dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_animate  (animate),
      .i_collide  (collide),
      .i_frog_y1  (frog_y1),
      .i_start    (start),
      .o_anim_en  (anim_en),
      .o_frog_rst (frog_rst),
      .o_dead     (dead),
      .o_flash    (flash),
      .o_lives    (lives),
      .o_score    (score),
      .o_level    (level),
      .o_state    (st)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One end-of-frame strobe cycle.
   task automatic strobe();
      animate = 1'b1;
      step();
      animate = 1'b0;
   endtask

   // With grace enabled, let the invulnerability window run out first.
   task automatic skip_grace();
`ifdef GAME_CTRL_GRACE_EN
      for (int i = 0; i < 90; i++) begin
         strobe();
         step();
      end
`endif
   endtask

   task automatic test_reset();
      step(); step();
      total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
      total++; if (lives !== 2'd0) begin bad++; $display("FAIL reset_lives got=%0d exp=0", lives); end
      total++; if (score !== 8'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
      total++; if (anim_en !== 1'b1) begin bad++; $display("FAIL reset_anim_en got=%0b exp=1", anim_en); end
      total++; if (frog_rst !== 1'b1) begin bad++; $display("FAIL reset_frog_rst got=%0b exp=1", frog_rst); end
      total++; if (dead !== 1'b0) begin bad++; $display("FAIL reset_dead got=%0b exp=0", dead); end
      total++; if (flash !== 1'b0) begin bad++; $display("FAIL reset_flash got=%0b exp=0", flash); end
      $display("test_reset: state=%0d lives=%0d frog_rst=%0b", st, lives, frog_rst);
   endtask

   // Start held through the tail of reset counts as one press.
   task automatic test_start();
      start = 1'b1;
      step();
      rst = 1'b0;
      step();
      total++; if (st !== 2'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", st); end
      total++; if (lives !== 2'd3) begin bad++; $display("FAIL start_lives got=%0d exp=3", lives); end
      total++; if (score !== 8'd0) begin bad++; $display("FAIL start_score got=%0d exp=0", score); end
      total++; if (frog_rst !== 1'b0) begin bad++; $display("FAIL start_frog_rst got=%0b exp=0", frog_rst); end
      step(); step(); step();
      total++; if (st !== 2'd1 || frog_rst !== 1'b0) begin bad++; $display("FAIL start_held got state=%0d frog_rst=%0b exp state=1 frog_rst=0", st, frog_rst); end
      start = 1'b0;
      step();
      $display("test_start: state=%0d lives=%0d", st, lives);
   endtask

   task automatic test_death();
      skip_grace();
      step();
      collide = 1'b1;
      step();
      collide = 1'b0;
      step(); step();
      strobe();
      total++; if (st !== 2'd2) begin bad++; $display("FAIL death_state got=%0d exp=2", st); end
      total++; if (lives !== 2'd2) begin bad++; $display("FAIL death_lives got=%0d exp=2", lives); end
      total++; if (anim_en !== 1'b0) begin bad++; $display("FAIL death_anim_en got=%0b exp=0", anim_en); end
      total++; if (dead !== 1'b1) begin bad++; $display("FAIL death_dead got=%0b exp=1", dead); end
      total++; if (flash !== 1'b1) begin bad++; $display("FAIL death_flash60 got=%0b exp=1", flash); end
      for (int i = 1; i <= 59; i++) begin
         strobe();
         if (i == 4) begin
            total++; if (flash !== 1'b1) begin bad++; $display("FAIL death_flash56 got=%0b exp=1", flash); end
         end
         if (i == 5) begin
            total++; if (flash !== 1'b0) begin bad++; $display("FAIL death_flash55 got=%0b exp=0", flash); end
         end
         step();
      end
      total++; if (st !== 2'd2) begin bad++; $display("FAIL death_len59 got=%0d exp=2", st); end
      strobe();
      total++; if (st !== 2'd1) begin bad++; $display("FAIL respawn_state got=%0d exp=1", st); end
      total++; if (frog_rst !== 1'b1) begin bad++; $display("FAIL respawn_pulse got=%0b exp=1", frog_rst); end
      total++; if (anim_en !== 1'b1 || dead !== 1'b0) begin bad++; $display("FAIL respawn_flags got anim_en=%0b dead=%0b exp 1 0", anim_en, dead); end
      step();
      total++; if (frog_rst !== 1'b0) begin bad++; $display("FAIL respawn_pulse_end got=%0b exp=0", frog_rst); end
      $display("test_death: state=%0d lives=%0d", st, lives);
   endtask

   task automatic test_goal();
      // First frame after respawn has no collision: must not die.
      strobe();
      step();
      total++; if (st !== 2'd1) begin bad++; $display("FAIL goal_no_carry got=%0d exp=1", st); end
      frog_y1 = 12'd20;
      strobe();
      total++; if (score !== 8'd1 || level !== 3'd1) begin bad++; $display("FAIL goal_first got score=%0d level=%0d exp 1 1", score, level); end
      total++; if (frog_rst !== 1'b1) begin bad++; $display("FAIL goal_pulse got=%0b exp=1", frog_rst); end
      step();
      total++; if (frog_rst !== 1'b0) begin bad++; $display("FAIL goal_pulse_end got=%0b exp=0", frog_rst); end
      for (int i = 0; i < 7; i++) begin
         strobe();
         step();
      end
      total++; if (score !== 8'd8) begin bad++; $display("FAIL goal_score8 got=%0d exp=8", score); end
      total++; if (level !== 3'd7) begin bad++; $display("FAIL goal_level_sat got=%0d exp=7", level); end
      frog_y1 = 12'd40;
      strobe();
      total++; if (score !== 8'd8) begin bad++; $display("FAIL goal_boundary40 got=%0d exp=8", score); end
      frog_y1 = 12'd400;
      skip_grace();
      frog_y1 = 12'd20;
      collide = 1'b1;
      strobe();
      collide = 1'b0;
      frog_y1 = 12'd400;
      total++; if (st !== 2'd2) begin bad++; $display("FAIL hit_goal_state got=%0d exp=2", st); end
      total++; if (score !== 8'd8 || lives !== 2'd1) begin bad++; $display("FAIL hit_goal_vals got score=%0d lives=%0d exp 8 1", score, lives); end
      for (int i = 0; i < 60; i++) begin
         strobe();
         step();
      end
      total++; if (st !== 2'd1) begin bad++; $display("FAIL hit_goal_respawn got=%0d exp=1", st); end
      $display("test_goal: score=%0d level=%0d lives=%0d", score, level, lives);
   endtask

   task automatic test_gameover();
      skip_grace();
      collide = 1'b1;
      strobe();
      collide = 1'b0;
      total++; if (lives !== 2'd0) begin bad++; $display("FAIL go_lives got=%0d exp=0", lives); end
      for (int i = 0; i < 60; i++) begin
         strobe();
         step();
      end
      total++; if (st !== 2'd3) begin bad++; $display("FAIL go_state got=%0d exp=3", st); end
      total++; if (dead !== 1'b1 || frog_rst !== 1'b1) begin bad++; $display("FAIL go_flags got dead=%0b frog_rst=%0b exp 1 1", dead, frog_rst); end
      total++; if (anim_en !== 1'b0 || flash !== 1'b0) begin bad++; $display("FAIL go_anim_flash got anim_en=%0b flash=%0b exp 0 0", anim_en, flash); end
      total++; if (score !== 8'd8 || level !== 3'd7) begin bad++; $display("FAIL go_hold got score=%0d level=%0d exp 8 7", score, level); end
      start = 1'b1;
      step();
      total++; if (st !== 2'd1 || lives !== 2'd3) begin bad++; $display("FAIL go_restart got state=%0d lives=%0d exp 1 3", st, lives); end
      total++; if (score !== 8'd0 || level !== 3'd0 || frog_rst !== 1'b0) begin bad++; $display("FAIL go_reload got score=%0d level=%0d frog_rst=%0b exp 0 0 0", score, level, frog_rst); end
      start = 1'b0;
      step();
      $display("test_gameover: state=%0d lives=%0d", st, lives);
   endtask

   task automatic test_first_frame();
      collide = 1'b1;
`ifdef GAME_CTRL_GRACE_EN
      for (int k = 1; k <= 90; k++) strobe();
      total++; if (st !== 2'd1 || lives !== 2'd3) begin bad++; $display("FAIL grace_ignore got state=%0d lives=%0d exp 1 3", st, lives); end
      strobe();
      total++; if (st !== 2'd2 || lives !== 2'd2) begin bad++; $display("FAIL grace_frame91 got state=%0d lives=%0d exp 2 2", st, lives); end
`else
      strobe();
      total++; if (st !== 2'd2 || lives !== 2'd2) begin bad++; $display("FAIL first_frame_kill got state=%0d lives=%0d exp 2 2", st, lives); end
`endif
      collide = 1'b0;
      step();
      $display("test_first_frame: state=%0d lives=%0d", st, lives);
   endtask

   task automatic test_reset_mid();
      strobe();
      strobe();
      rst = 1'b1;
      animate = 1'b1;
      start = 1'b1;
      step();
      total++; if (st !== 2'd0 || lives !== 2'd0) begin bad++; $display("FAIL rstmid_state got state=%0d lives=%0d exp 0 0", st, lives); end
      total++; if (anim_en !== 1'b1 || frog_rst !== 1'b1) begin bad++; $display("FAIL rstmid_anim_frog got anim_en=%0b frog_rst=%0b exp 1 1", anim_en, frog_rst); end
      total++; if (dead !== 1'b0 || flash !== 1'b0) begin bad++; $display("FAIL rstmid_dead_flash got dead=%0b flash=%0b exp 0 0", dead, flash); end
      rst = 1'b0;
      animate = 1'b0;
      start = 1'b0;
      step(); step();
      total++; if (st !== 2'd0) begin bad++; $display("FAIL rstmid_stay_idle got=%0d exp=0", st); end
      $display("test_reset_mid: state=%0d", st);
   endtask

   initial begin
      #1;
      test_reset();
      test_start();
      test_death();
      test_goal();
      test_gameover();
      test_first_frame();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Frame-level game sequencer for the VGA frog game. It sits between the pixel-compare logic and the animated sprites, and accumulates per-pixel frog/obstacle overlap into a per-frame hit. It runs the attract/play/dying/game-over state machine, tracks lives, score and level, and gates obstacle animation. It also issues frog respawn requests and drives the death-flash indication used by the colour mux.

## Interface
Parameters:
- `LIVES`, 3: lives at game start; 1..3.
- `GOAL_Y`, 40: the frog has scored when `i_frog_y1 < GOAL_Y`.
- `DEATH_FRAMES`, 60: length of the dying freeze, in frames; must be ≥1.
- `GRACE_FRAMES`, 90: post-respawn invulnerability, in frames. Used only when `GAME_CTRL_GRACE_EN` is defined.
- `MAX_LEVEL`, 7: level saturates here.
- `SCORE_W`, 8: score counter width.

Ports:
- `i_clk`, in, 1: system clock (100 MHz).
- `i_rst`, in, 1: reset. Synchronous, active-high.
- `i_animate`, in, 1: single-cycle end-of-frame strobe from the VGA timing block.
- `i_collide`, in, 1: frog pixel AND any obstacle pixel, valid every cycle.
- `i_frog_y1`, in, 12: frog top edge.
- `i_start`, in, 1: start button, already synchronised and debounced, active-high.
- `o_anim_en`, out, 1: enables obstacle animation.
- `o_frog_rst`, out, 1: frog return-to-start request.
- `o_dead`, out, 1: high in DYING and GAMEOVER.
- `o_flash`, out, 1: blink signal for the colour mux.
- `o_lives`, out, 2: remaining lives.
- `o_score`, out, SCORE_W: goals reached.
- `o_level`, out, 3: current level.
- `o_state`, out, 2: IDLE=0, PLAY=1, DYING=2, GAMEOVER=3.

## Operation
- **Hit accumulator:** `hit_q` is set by any cycle with `i_collide` high. Frame hit = `hit_q | i_collide` sampled on the `i_animate` cycle. `hit_q` clears on that same edge and does not carry into the next frame.
- **Start edge:** `start_q` resets to 0, and a press is `i_start & ~start_q`. A button held through reset therefore counts as one press on the first cycle after reset.
- **IDLE:**
  - `o_anim_en` = 1 (attract mode); `o_frog_rst` held high.
  - A press moves to PLAY and loads lives = `LIVES`, score = 0, level = 0.
- **PLAY:**
  - `o_anim_en` = 1. All decisions are taken only on `i_animate`.
  - Frame hit: move to DYING, decrement lives, load the timer with `DEATH_FRAMES`.
  - Otherwise, if `i_frog_y1 < GOAL_Y`: score +1 (saturating at all-ones), level +1 (saturating at `MAX_LEVEL`), one-cycle `o_frog_rst`, stay in PLAY.
  - Hit and goal in the same frame: hit wins and score is unchanged.
  - Presses are ignored.
- **DYING:**
  - `o_anim_en` = 0; `o_dead` = 1; `o_flash` = bit 3 of the remaining-frame count.
  - The timer decrements once per `i_animate`. When it reaches 0, on that strobe: lives == 0 goes to GAMEOVER; otherwise pulse `o_frog_rst` for one cycle and return to PLAY.
- **GAMEOVER:**
  - `o_anim_en` = 0; `o_dead` = 1; `o_flash` = 0; `o_frog_rst` held high; score and level held.
  - A press goes to PLAY with the same reload as from IDLE.
- `o_flash` is 0 in every state not listed above.

## Timing
- **Registered outputs:** every output is registered and changes on the clock edge that samples `i_animate` or the press. Latency is 1 cycle.
- **`o_frog_rst` pulses:** a pulse is exactly 1 cycle long, asserted in the cycle after the evaluating edge. On IDLE/GAMEOVER to PLAY, the held-high `o_frog_rst` drops 1 cycle after the press.
- **Reset values:** state IDLE, lives 0, score 0, level 0, `o_anim_en` 1, `o_frog_rst` 1, `o_dead` 0, `o_flash` 0, `hit_q` 0, timers 0.
- **Reset mid-operation:** reset asserted in any state returns everything to the reset values on the next edge and takes priority over a coincident `i_animate` or press.
- **`i_collide` coinciding with `i_animate`:** the collision counts for the ending frame.
- **Frame timing:** the `DYING` length is exactly `DEATH_FRAMES` strobes, counting from the strobe after entry.

## Configuration
- Macro: `GAME_CTRL_GRACE_EN`.
- **Defined:**
  - On every entry to PLAY (from start or respawn), a grace timer loads `GRACE_FRAMES`.
  - While the timer is non-zero, frame hits are ignored (a goal is still scored) and `o_flash` = bit 2 of the timer.
  - The timer decrements per `i_animate` and is cleared by reset.
- **Undefined:** no grace timer; hits are effective in the first PLAY frame; `o_flash` is 0 in PLAY.

## Structure
- **Package `game_pkg`:**
  - state enum and `o_state` encoding;
  - `LIVES_W` = 2, `LEVEL_W` = 3;
  - default `GOAL_Y`, `DEATH_FRAMES` and `GRACE_FRAMES` constants.
- **Sub-module `frame_timer`:** a loadable down-counter decremented on `i_animate`, with a `zero` flag. It is instantiated once for the death timer, and once more for grace when `GAME_CTRL_GRACE_EN` is defined.

## Test plan
- Reset, then hold `i_start` high → one cycle later state = PLAY, lives = 3, score = 0; `o_frog_rst` falls one cycle after the press and no second start occurs while held.
- In PLAY, raise `i_collide` for 1 cycle mid-frame, then `i_animate` → DYING, lives = 2, `o_anim_en` = 0. After 60 strobes → PLAY with a 1-cycle `o_frog_rst`.
- With `i_frog_y1` = 20 at `i_animate` → score 1, level 1, 1-cycle `o_frog_rst`. Repeat 8 times → level saturates at 7. Hit and goal in the same frame → DYING and score unchanged.
- Three deaths → GAMEOVER, `o_dead` = 1, `o_frog_rst` = 1. A press → PLAY, lives = 3, score = 0.
- With `GAME_CTRL_GRACE_EN`: a hit within 90 frames of respawn is ignored and a hit at frame 91 kills. Without the macro, a hit in the first frame kills.
- Assert `i_rst` in DYING, in the same cycle as `i_animate` → IDLE with all reset values on the next edge.
